// File: rtl/holy_core_pkg.sv
// holy_core_pkg: cache-wide types and line geometry.
package holy_core_pkg;
  localparam int CACHE_LINE_WORDS = 128;
  typedef enum logic [2:0] {
    IDLE,
    SENDING_WRITE_REQ,
    SENDING_WRITE_DATA,
    WAITING_WRITE_RES,
    SENDING_READ_REQ,
    RECEIVING_READ_DATA
  } cache_state_t;
endpackage

// File: rtl/axi_if.sv
// axi_if: AXI4 bundle with 32-bit data and 4-bit IDs.
interface axi_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [3:0]            awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid, awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wlast, wvalid, wready;
  logic [1:0]            bresp;
  logic                  bvalid, bready;
  logic [3:0]            arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid, arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast, rvalid, rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid,
           bready, arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/cache_axi_burst_engine.sv
// cache_axi_burst_engine: per-cache AXI master turning a miss into an optional
// dirty-line writeback burst followed by a line-fill read burst.
module cache_axi_burst_engine
  import holy_core_pkg::*;
#(
  parameter int LINE_WORDS = CACHE_LINE_WORDS,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  axi_if.master                         m_axi,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_dirty_i,
  input  logic [ADDR_WIDTH-1:0]         req_wb_addr_i,
  input  logic [ADDR_WIDTH-1:0]         req_fill_addr_i,
  output logic [$clog2(LINE_WORDS)-1:0] wb_word_idx_o,
  input  logic [31:0]                   wb_word_data_i,
  output logic                          fill_word_valid_o,
  output logic [$clog2(LINE_WORDS)-1:0] fill_word_idx_o,
  output logic [31:0]                   fill_word_data_o,
  output logic                          done_o,
  output logic                          resp_err_o,
  output cache_state_t                  state_o
);
  localparam int IW = $clog2(LINE_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);

  cache_state_t          state_q, state_d;
  logic [IW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d, fill_addr_q, fill_addr_d;
  logic                  err_q, err_d, last_beat, beat_err;

  // LINE_WORDS is a power of two, so the final beat index is all ones
  assign last_beat = &cnt_q;
  assign beat_err  = (state_q == WAITING_WRITE_RES && m_axi.bvalid && m_axi.bresp != 2'b00) ||
                     (state_q == RECEIVING_READ_DATA && m_axi.rvalid &&
                      (m_axi.rresp != 2'b00 || m_axi.rlast != last_beat));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wb_addr_q   <= '0;
      fill_addr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_addr_q   <= wb_addr_d;
      fill_addr_q <= fill_addr_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wb_addr_d   = wb_addr_q;
    fill_addr_d = fill_addr_q;
    err_d       = err_q | beat_err;
    unique case (state_q)
      IDLE: if (req_valid_i) begin
        state_d     = req_dirty_i ? SENDING_WRITE_REQ : SENDING_READ_REQ;
        wb_addr_d   = req_wb_addr_i & LINE_MASK;
        fill_addr_d = req_fill_addr_i & LINE_MASK;
        err_d       = 1'b0;
      end
      SENDING_WRITE_REQ: if (m_axi.awready) begin
        state_d = SENDING_WRITE_DATA;
        cnt_d   = '0;
      end
      SENDING_WRITE_DATA: if (m_axi.wready) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = last_beat ? WAITING_WRITE_RES : state_q;
      end
      WAITING_WRITE_RES: state_d = m_axi.bvalid ? SENDING_READ_REQ : state_q;
      SENDING_READ_REQ: if (m_axi.arready) begin
        state_d = RECEIVING_READ_DATA;
        cnt_d   = '0;
      end
      RECEIVING_READ_DATA: if (m_axi.rvalid) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = m_axi.rlast ? IDLE : state_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o       = state_q == IDLE;
    m_axi.awvalid     = state_q == SENDING_WRITE_REQ;
    m_axi.awaddr      = wb_addr_q;
    m_axi.wvalid      = state_q == SENDING_WRITE_DATA;
    m_axi.wdata       = wb_word_data_i;
    m_axi.wlast       = state_q == SENDING_WRITE_DATA && last_beat;
    wb_word_idx_o     = cnt_q;
    m_axi.bready      = state_q == WAITING_WRITE_RES;
    m_axi.arvalid     = state_q == SENDING_READ_REQ;
    m_axi.araddr      = fill_addr_q;
    m_axi.rready      = state_q == RECEIVING_READ_DATA;
    fill_word_valid_o = state_q == RECEIVING_READ_DATA && m_axi.rvalid;
    fill_word_idx_o   = cnt_q;
    fill_word_data_o  = m_axi.rdata;
    done_o            = state_q == RECEIVING_READ_DATA && m_axi.rvalid && m_axi.rlast;
    resp_err_o        = err_q | beat_err;
    state_o           = state_q;
  end

  assign m_axi.awid    = '0;
  assign m_axi.awlen   = 8'(LINE_WORDS - 1);
  assign m_axi.awsize  = 3'b010;
  assign m_axi.awburst = 2'b01;
  assign m_axi.wstrb   = 4'b1111;
  assign m_axi.arid    = '0;
  assign m_axi.arlen   = 8'(LINE_WORDS - 1);
  assign m_axi.arsize  = 3'b010;
  assign m_axi.arburst = 2'b01;
endmodule

// File: tb/tb_cache_axi_burst_engine.sv
// tb_cache_axi_burst_engine: directed miss sequences against a cycle-stepped AXI slave,
// with hand-computed expectations for latency, addresses, beats and error reporting.
module tb_cache_axi_burst_engine;
  import holy_core_pkg::*;
  localparam int LW = 128;
  localparam int IW = $clog2(LW);

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_if #(.ADDR_WIDTH(32)) axi ();
  logic req_valid = 1'b0, req_ready, req_dirty = 1'b0;
  logic [31:0] req_wb_addr = '0, req_fill_addr = '0;
  logic [IW-1:0] wb_word_idx, fill_word_idx;
  logic [31:0] wb_word_data, fill_word_data;
  logic fill_word_valid, done, resp_err;
  cache_state_t state;

  assign wb_word_data = 32'hA500_0000 | 32'(wb_word_idx);

  cache_axi_burst_engine #(.LINE_WORDS(LW), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .m_axi(axi),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_dirty_i(req_dirty),
    .req_wb_addr_i(req_wb_addr), .req_fill_addr_i(req_fill_addr),
    .wb_word_idx_o(wb_word_idx), .wb_word_data_i(wb_word_data),
    .fill_word_valid_o(fill_word_valid), .fill_word_idx_o(fill_word_idx),
    .fill_word_data_o(fill_word_data), .done_o(done), .resp_err_o(resp_err), .state_o(state)
  );

  int checks = 0, fails = 0;
  int done_cyc, done_cnt, wbeats, fbeats, idx_err, wlast_err, stab_err, fill_err, field_err;
  logic err_done, err_c1, err_c2, post_ready, post_err, rst_arv, rst_rr, rst_fv;
  cache_state_t post_state, rst_state;
  logic [31:0] aw_seen, ar_seen;
  logic [47:0] seq;

  task automatic run_cmd(input logic dirty, input logic [31:0] wa, input logic [31:0] fa,
                         input bit bp, input bit berr, input int rerr_beat,
                         input int rlast_beat, input int rst_beat);
    bit ar_done = 0, b_done = 0, pa = 0, pw = 0, par = 0, acc;
    logic [31:0] pwdata = '0;
    int rb = 0, c = 1;
    cache_state_t last = state;
    done_cyc = -1; done_cnt = 0; wbeats = 0; fbeats = 0; idx_err = 0; wlast_err = 0;
    stab_err = 0; fill_err = 0; field_err = 0; seq = '0; err_done = 1'bx;
    err_c1 = 1'bx; err_c2 = 1'bx; aw_seen = '1; ar_seen = '1;
    rst_arv = 1'b1; rst_rr = 1'b1; rst_fv = 1'b1; rst_state = RECEIVING_READ_DATA;
    req_valid = 1'b1; req_dirty = dirty; req_wb_addr = wa; req_fill_addr = fa;
    while (done_cnt == 0 && c < 3000) begin
      axi.awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.arready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.bvalid  = wbeats == LW && !b_done;
      axi.bresp   = berr ? 2'b10 : 2'b00;
      axi.rvalid  = ar_done && rb <= rlast_beat && (!bp || $urandom_range(0, 1) == 1);
      axi.rdata   = 32'(rb);
      axi.rresp   = rb == rerr_beat ? 2'b10 : 2'b00;
      axi.rlast   = rb == rlast_beat;
      #2;
      if (rst_beat >= 0 && axi.rvalid && rb == rst_beat) begin
        rst_n = 1'b0;
        #1;
        rst_arv = axi.arvalid; rst_rr = axi.rready; rst_fv = fill_word_valid; rst_state = state;
        axi.rvalid = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (c == 1) err_c1 = resp_err;
      if (c == 2) err_c2 = resp_err;
      if (state !== last) begin seq = {seq[44:0], 3'(state)}; last = state; end
      if (pa && (!axi.awvalid || axi.awaddr !== aw_seen)) stab_err++;
      if (axi.awvalid) begin
        aw_seen = axi.awaddr;
        if ({axi.awid, axi.awlen, axi.awsize, axi.awburst} !== {4'd0, 8'(LW - 1), 3'b010, 2'b01}) field_err++;
      end
      pa = axi.awvalid && !axi.awready;
      if (pw && (!axi.wvalid || axi.wdata !== pwdata)) stab_err++;
      if (axi.wvalid) begin
        if (wb_word_idx !== IW'(wbeats) || axi.wdata !== (32'hA500_0000 | 32'(wbeats))) idx_err++;
        if (axi.wlast !== (wbeats == LW - 1) || axi.wstrb !== 4'hF) wlast_err++;
        if (axi.wready) wbeats++;
      end
      pw = axi.wvalid && !axi.wready; pwdata = axi.wdata;
      if (axi.bvalid && axi.bready) b_done = 1;
      if (par && (!axi.arvalid || axi.araddr !== ar_seen)) stab_err++;
      if (axi.arvalid) begin
        ar_seen = axi.araddr;
        if ({axi.arid, axi.arlen, axi.arsize, axi.arburst} !== {4'd0, 8'(LW - 1), 3'b010, 2'b01}) field_err++;
        if (axi.arready) ar_done = 1;
      end
      par = axi.arvalid && !axi.arready;
      if (fill_word_valid !== (axi.rvalid && axi.rready)) fill_err++;
      if (axi.rvalid && axi.rready) begin
        if (fill_word_idx !== IW'(rb) || fill_word_data !== 32'(rb)) idx_err++;
        fbeats++; rb++;
      end
      if (done) begin done_cnt++; done_cyc = c; err_done = resp_err; end
      acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc) req_valid = 1'b0;
      c++;
    end
    axi.rvalid = 1'b0; axi.bvalid = 1'b0; req_valid = 1'b0;
    #2;
    post_ready = req_ready; post_err = resp_err; post_state = state;
    if (state !== last) seq = {seq[44:0], 3'(state)};
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++;
    if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, done, fill_word_valid, resp_err} !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, done, fill_word_valid, resp_err});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_fill;
    run_cmd(1'b0, 32'h0, 32'h0000_1234, 0, 0, -1, LW - 1, -1);
    checks++; if (done_cyc !== 130) begin fails++; $display("FAIL clean_done_cycle: got %0d expected 130", done_cyc); end
    checks++; if (ar_seen !== 32'h0000_1200) begin fails++; $display("FAIL clean_araddr: got %h expected 00001200", ar_seen); end
    checks++; if (fbeats !== LW) begin fails++; $display("FAIL clean_fill_beats: got %0d expected %0d", fbeats, LW); end
    checks++; if (idx_err + fill_err + field_err !== 0) begin fails++; $display("FAIL clean_beat_errors: got %0d expected 0", idx_err + fill_err + field_err); end
    checks++; if (err_done !== 1'b0) begin fails++; $display("FAIL clean_resp_err: got %b expected 0", err_done); end
    checks++; if (post_ready !== 1'b1) begin fails++; $display("FAIL clean_ready_after_done: got %b expected 1", post_ready); end
    checks++;
    if (seq !== 48'({SENDING_READ_REQ, RECEIVING_READ_DATA, IDLE})) begin
      fails++; $display("FAIL clean_state_seq: got %h expected %h", seq, 48'({SENDING_READ_REQ, RECEIVING_READ_DATA, IDLE}));
    end
  endtask

  task automatic test_dirty_miss;
    run_cmd(1'b1, 32'h0000_2044, 32'h0000_4000, 0, 0, -1, LW - 1, -1);
    checks++; if (done_cyc !== 260) begin fails++; $display("FAIL dirty_done_cycle: got %0d expected 260", done_cyc); end
    checks++; if (aw_seen !== 32'h0000_2000) begin fails++; $display("FAIL dirty_awaddr: got %h expected 00002000", aw_seen); end
    checks++; if (ar_seen !== 32'h0000_4000) begin fails++; $display("FAIL dirty_araddr: got %h expected 00004000", ar_seen); end
    checks++; if (wbeats !== LW) begin fails++; $display("FAIL dirty_write_beats: got %0d expected %0d", wbeats, LW); end
    checks++; if (wlast_err !== 0) begin fails++; $display("FAIL dirty_wlast: got %0d bad beats expected 0", wlast_err); end
    checks++; if (idx_err + field_err !== 0) begin fails++; $display("FAIL dirty_beat_errors: got %0d expected 0", idx_err + field_err); end
    checks++;
    if (seq !== 48'({SENDING_WRITE_REQ, SENDING_WRITE_DATA, WAITING_WRITE_RES, SENDING_READ_REQ, RECEIVING_READ_DATA, IDLE})) begin
      fails++; $display("FAIL dirty_state_seq: got %h expected %h", seq,
        48'({SENDING_WRITE_REQ, SENDING_WRITE_DATA, WAITING_WRITE_RES, SENDING_READ_REQ, RECEIVING_READ_DATA, IDLE}));
    end
    checks++; if (err_done !== 1'b0) begin fails++; $display("FAIL dirty_resp_err: got %b expected 0", err_done); end
  endtask

  task automatic test_backpressure;
    run_cmd(1'b1, 32'h0000_6000, 32'h0000_7000, 1, 0, -1, LW - 1, -1);
    checks++; if (done_cnt !== 1) begin fails++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
    checks++; if (wbeats !== LW || fbeats !== LW) begin fails++; $display("FAIL bp_beats: got w=%0d r=%0d expected %0d", wbeats, fbeats, LW); end
    checks++; if (stab_err !== 0) begin fails++; $display("FAIL bp_stability: got %0d expected 0", stab_err); end
    checks++; if (idx_err + wlast_err + fill_err !== 0) begin fails++; $display("FAIL bp_indices: got %0d expected 0", idx_err + wlast_err + fill_err); end
    checks++; if (err_done !== 1'b0) begin fails++; $display("FAIL bp_resp_err: got %b expected 0", err_done); end
  endtask

  task automatic test_errors;
    run_cmd(1'b1, 32'h0000_8000, 32'h0000_9000, 0, 1, -1, LW - 1, -1);
    checks++; if (done_cyc !== 260) begin fails++; $display("FAIL bresp_done_cycle: got %0d expected 260", done_cyc); end
    checks++; if (err_done !== 1'b1) begin fails++; $display("FAIL bresp_resp_err: got %b expected 1", err_done); end
    run_cmd(1'b1, 32'h0000_8000, 32'h0000_9000, 0, 0, 5, LW - 1, -1);
    checks++; if (err_c2 !== 1'b0) begin fails++; $display("FAIL err_cleared_on_accept: got %b expected 0", err_c2); end
    checks++; if (fbeats !== LW) begin fails++; $display("FAIL rresp_fill_beats: got %0d expected %0d", fbeats, LW); end
    checks++; if (err_done !== 1'b1) begin fails++; $display("FAIL rresp_resp_err: got %b expected 1", err_done); end
    checks++; if (post_err !== 1'b1) begin fails++; $display("FAIL err_sticky_after_done: got %b expected 1", post_err); end
  endtask

  task automatic test_err_clear;
    run_cmd(1'b0, 32'h0, 32'h0000_B000, 0, 0, -1, LW - 1, -1);
    checks++; if (err_c1 !== 1'b1) begin fails++; $display("FAIL err_held_until_accept: got %b expected 1", err_c1); end
    checks++; if (err_c2 !== 1'b0) begin fails++; $display("FAIL err_clear_after_accept: got %b expected 0", err_c2); end
    checks++; if (err_done !== 1'b0) begin fails++; $display("FAIL err_clear_done: got %b expected 0", err_done); end
  endtask

  task automatic test_premature_rlast;
    run_cmd(1'b0, 32'h0, 32'h0000_A000, 0, 0, -1, 63, -1);
    checks++; if (done_cyc !== 66) begin fails++; $display("FAIL early_done_cycle: got %0d expected 66", done_cyc); end
    checks++; if (fbeats !== 64) begin fails++; $display("FAIL early_fill_beats: got %0d expected 64", fbeats); end
    checks++; if (err_done !== 1'b1) begin fails++; $display("FAIL early_resp_err: got %b expected 1", err_done); end
    checks++;
    if (post_ready !== 1'b1 || post_state !== IDLE) begin
      fails++; $display("FAIL early_idle_after: got ready=%b state=%0d expected ready=1 state=%0d", post_ready, post_state, IDLE);
    end
  endtask

  task automatic test_missing_rlast;
    run_cmd(1'b0, 32'h0, 32'h0000_C000, 0, 0, -1, LW + 1, -1);
    checks++; if (done_cyc !== LW + 4) begin fails++; $display("FAIL late_done_cycle: got %0d expected %0d", done_cyc, LW + 4); end
    checks++; if (fbeats !== LW + 2 || idx_err !== 0) begin fails++; $display("FAIL late_wrap: got beats=%0d idx_err=%0d expected %0d/0", fbeats, idx_err, LW + 2); end
    checks++; if (err_done !== 1'b1) begin fails++; $display("FAIL late_resp_err: got %b expected 1", err_done); end
  endtask

  task automatic test_reset_mid_burst;
    run_cmd(1'b0, 32'h0, 32'h0000_D000, 0, 0, -1, LW - 1, 40);
    checks++;
    if ({rst_arv, rst_rr, rst_fv} !== 3'b000) begin
      fails++; $display("FAIL rst_mid_valids: got %b expected 000", {rst_arv, rst_rr, rst_fv});
    end
    checks++; if (rst_state !== IDLE) begin fails++; $display("FAIL rst_mid_state: got %0d expected %0d", rst_state, IDLE); end
    checks++; if (done_cnt !== 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d expected 0", done_cnt); end
    run_cmd(1'b0, 32'h0, 32'h0000_E000, 0, 0, -1, LW - 1, -1);
    checks++; if (done_cyc !== 130 || fbeats !== LW) begin fails++; $display("FAIL rst_recover: got cyc=%0d beats=%0d expected 130/%0d", done_cyc, fbeats, LW); end
    checks++; if (err_done !== 1'b0 || ar_seen !== 32'h0000_E000) begin fails++; $display("FAIL rst_recover_fields: got err=%b araddr=%h expected 0/0000e000", err_done, ar_seen); end
  endtask

  initial begin
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
    test_reset();
    test_clean_fill();
    test_dirty_miss();
    test_backpressure();
    test_errors();
    test_err_clear();
    test_premature_rlast();
    test_missing_rlast();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end
endmodule
